// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        CellEmpty = 2'b00,
        CellX     = 2'b01,
        CellO     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        GsIdle    = 2'b00,
        GsPlaying = 2'b01,
        GsWin     = 2'b10,
        GsDraw    = 2'b11
    } game_state_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitMove,
        StCheck,
        StWin,
        StDraw
    } fsm_state_t;

    localparam int unsigned N_CELLS = 9;

    // Rows, columns, diagonal, anti-diagonal; bit order of win_line follows this table.
    localparam int unsigned WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic game_state_t to_game_state(input fsm_state_t st);
        game_state_t gs;
        unique case (st)
            StWaitMove, StCheck: gs = GsPlaying;
            StWin:               gs = GsWin;
            StDraw:              gs = GsDraw;
            default:             gs = GsIdle;
        endcase
        return gs;
    endfunction

    function automatic cell_t player_cell(input logic turn);
        return turn ? CellO : CellX;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags every line fully owned by the given player.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  cell_t       player,
    output logic        hit,
    output logic [7:0]  line
);

    for (genvar l = 0; l < 8; l++) begin : g_line
        assign line[l] = (board[2*WIN_LINES[l][0] +: 2] == player) &&
                         (board[2*WIN_LINES[l][1] +: 2] == player) &&
                         (board[2*WIN_LINES[l][2] +: 2] == player);
    end

    assign hit = |line;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Two-player tic-tac-toe sequencer with per-turn timeout and a frame-synchronous
// board snapshot for the sprite renderer.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned TURN_TIMEOUT_S = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    input  logic        frame_tick,
    output logic        move_ready,
    output logic        move_reject,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic [3:0]  timer_sec
);

    localparam int unsigned   PW         = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ_HZ - 1);
    localparam logic [3:0]    TIMER_LOAD = 4'(TURN_TIMEOUT_S);
    localparam bit            TIMER_EN   = (TURN_TIMEOUT_S > 0);

    fsm_state_t     state_q;
    logic [17:0]    board_q;
    logic           turn_q;
    logic [3:0]     count_q;
    logic [1:0]     winner_q;
    logic [7:0]     win_line_q;
    logic [3:0]     timer_q;
    logic [PW-1:0]  presc_q;
    logic           reject_q;

    logic [17:0]    snap_board_q;
    logic           snap_turn_q;
    logic [1:0]     snap_state_q;
    logic [1:0]     snap_winner_q;
    logic [7:0]     snap_line_q;

    cell_t          player;
    logic [3:0]     cell_idx;
    logic           move_legal;
    logic           line_hit;
    logic [7:0]     line_vec;

    assign player   = player_cell(turn_q);
    // Clamp out-of-range cells so the board slice below always stays in bounds.
    assign cell_idx = (move_cell <= 4'd8) ? move_cell : 4'd0;
    assign move_legal = (state_q == StWaitMove) && move_valid && (move_cell <= 4'd8) &&
                        (board_q[{cell_idx, 1'b0} +: 2] == CellEmpty);

    ttt_line_check u_line_check (
        .board  (board_q),
        .player (player),
        .hit    (line_hit),
        .line   (line_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            board_q       <= '0;
            turn_q        <= 1'b0;
            count_q       <= '0;
            winner_q      <= '0;
            win_line_q    <= '0;
            timer_q       <= '0;
            presc_q       <= '0;
            reject_q      <= 1'b0;
            snap_board_q  <= '0;
            snap_turn_q   <= 1'b0;
            snap_state_q  <= '0;
            snap_winner_q <= '0;
            snap_line_q   <= '0;
        end else begin
            reject_q <= 1'b0;

            if (frame_tick) begin
                snap_board_q  <= board_q;
                snap_turn_q   <= turn_q;
                snap_state_q  <= to_game_state(state_q);
                snap_winner_q <= winner_q;
                snap_line_q   <= win_line_q;
            end

            if (start) begin
                state_q    <= StWaitMove;
                board_q    <= '0;
                turn_q     <= 1'b0;
                count_q    <= '0;
                winner_q   <= '0;
                win_line_q <= '0;
                timer_q    <= TIMER_LOAD;
                presc_q    <= '0;
            end else begin
                unique case (state_q)
                    StWaitMove: begin
                        if (move_legal) begin
                            // A legal move freezes the timer, beating a same-cycle forfeit.
                            board_q[{cell_idx, 1'b0} +: 2] <= player;
                            if (count_q != 4'(N_CELLS)) count_q <= count_q + 4'd1;
                            state_q <= StCheck;
                        end else begin
                            reject_q <= move_valid;
                            if (TIMER_EN) begin
                                if (presc_q == PRESC_MAX) begin
                                    presc_q <= '0;
                                    if (timer_q == 4'd1) begin
                                        turn_q  <= ~turn_q;
                                        timer_q <= TIMER_LOAD;
                                    end else begin
                                        timer_q <= timer_q - 4'd1;
                                    end
                                end else begin
                                    presc_q <= presc_q + 1'b1;
                                end
                            end
                        end
                    end
                    StCheck: begin
                        if (line_hit) begin
                            state_q    <= StWin;
                            winner_q   <= player;
                            win_line_q <= line_vec;
                        end else if (count_q == 4'(N_CELLS)) begin
                            state_q <= StDraw;
                        end else begin
                            turn_q  <= ~turn_q;
                            timer_q <= TIMER_LOAD;
                            presc_q <= '0;
                            state_q <= StWaitMove;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign move_ready  = (state_q == StWaitMove);
    assign move_reject = reject_q;
    assign board       = snap_board_q;
    assign turn        = snap_turn_q;
    assign game_state  = snap_state_q;
    assign winner      = snap_winner_q;
    assign win_line    = snap_line_q;
    assign timer_sec   = timer_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl (10 Hz prescaler, 3 s turns, frame every 50).
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic        frame_tick;
    logic        move_ready;
    logic        move_reject;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  game_state;
    logic [1:0]  winner;
    logic [7:0]  win_line;
    logic [3:0]  timer_sec;

    int errors = 0;
    int checks = 0;
    int fcnt   = 0;

    ttt_game_ctrl #(
        .CLK_FREQ_HZ    (10),
        .TURN_TIMEOUT_S (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .move_valid  (move_valid),
        .move_cell   (move_cell),
        .frame_tick  (frame_tick),
        .move_ready  (move_ready),
        .move_reject (move_reject),
        .board       (board),
        .turn        (turn),
        .game_state  (game_state),
        .winner      (winner),
        .win_line    (win_line),
        .timer_sec   (timer_sec)
    );

    always #5 clk = ~clk;

    // Free-running frame tick: one cycle high every 50 cycles.
    initial begin
        frame_tick = 1'b0;
        forever begin
            @(negedge clk);
            fcnt = (fcnt == 49) ? 0 : fcnt + 1;
            frame_tick = (fcnt == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_move(input logic [3:0] c);
        @(negedge clk);
        move_valid = 1'b1;
        move_cell  = c;
        @(negedge clk) move_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!frame_tick && n < 200);
        if (!frame_tick) begin
            checks++; errors++;
            $display("FAIL frame_wait: got no frame_tick expected one within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic align_fcnt(input int target);
        @(posedge clk);
        while (fcnt != target) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL rst_board: got %h expected 0", board); end
        checks++; if ({turn, game_state, winner, win_line} !== 13'h0) begin errors++;
            $display("FAIL rst_status: got %h expected 0", {turn, game_state, winner, win_line}); end
        checks++; if ({move_ready, move_reject, timer_sec} !== 6'h0) begin errors++;
            $display("FAIL rst_ctrl: got %h expected 0", {move_ready, move_reject, timer_sec}); end
        rst_n = 1'b1;
        do_move(4'd0);
        checks++; if ({move_ready, move_reject} !== 2'b00) begin errors++;
            $display("FAIL idle_move: got %b expected 00", {move_ready, move_reject}); end
    endtask

    task automatic test_win();
        do_start();
        checks++; if (timer_sec !== 4'd3 || move_ready !== 1'b1) begin errors++;
            $display("FAIL start_timer: got %0d/%b expected 3/1", timer_sec, move_ready); end
        do_move(4'd0); do_move(4'd3); do_move(4'd1); do_move(4'd4); do_move(4'd2);
        checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL win_ready: got %b expected 0", move_ready); end
        wait_frame();
        checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL win_state: got %b expected 10", game_state); end
        checks++; if (winner !== 2'b01) begin errors++; $display("FAIL win_winner: got %b expected 01", winner); end
        checks++; if (win_line !== 8'h01) begin errors++; $display("FAIL win_line: got %h expected 01", win_line); end
        checks++; if (board !== 18'h00295) begin errors++; $display("FAIL win_board: got %h expected 00295", board); end
        checks++; if (turn !== 1'b0) begin errors++; $display("FAIL win_turn: got %b expected 0", turn); end
        do_move(4'd5);
        checks++; if (move_reject !== 1'b0) begin errors++; $display("FAIL win_hold: got reject %b expected 0", move_reject); end
    endtask

    task automatic test_draw();
        do_start();
        do_move(4'd0); do_move(4'd1); do_move(4'd2); do_move(4'd4);
        do_move(4'd3); do_move(4'd6); do_move(4'd7); do_move(4'd8);
        checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL draw_ready8: got %b expected 1", move_ready); end
        do_move(4'd5);
        checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL draw_ready9: got %b expected 0", move_ready); end
        wait_frame();
        checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL draw_state: got %b expected 11", game_state); end
        checks++; if ({winner, win_line} !== 10'h0) begin errors++;
            $display("FAIL draw_result: got %h expected 0", {winner, win_line}); end
        checks++; if (board !== 18'h26659) begin errors++; $display("FAIL draw_board: got %h expected 26659", board); end
    endtask

    task automatic test_reject();
        align_fcnt(30);
        do_start();
        do_move(4'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            move_valid = 1'b1;
            move_cell  = (k == 0) ? 4'd4 : 4'd9;
            @(negedge clk) move_valid = 1'b0;
            checks++; if (move_reject !== 1'b1 || move_ready !== 1'b1) begin errors++;
                $display("FAIL reject_pulse%0d: got %b%b expected 11", k, move_reject, move_ready); end
            @(negedge clk);
            checks++; if (move_reject !== 1'b0) begin errors++;
                $display("FAIL reject_single%0d: got %b expected 0", k, move_reject); end
        end
        wait_frame();
        checks++; if (board !== 18'h00100) begin errors++; $display("FAIL reject_board: got %h expected 00100", board); end
        checks++; if (turn !== 1'b1 || game_state !== 2'b01) begin errors++;
            $display("FAIL reject_turn: got %b/%b expected 1/01", turn, game_state); end
    endtask

    task automatic test_timeout();
        do_start();
        repeat (9) @(negedge clk);
        checks++; if (timer_sec !== 4'd3) begin errors++; $display("FAIL tmo_c9: got %0d expected 3", timer_sec); end
        @(negedge clk);
        checks++; if (timer_sec !== 4'd2) begin errors++; $display("FAIL tmo_c10: got %0d expected 2", timer_sec); end
        repeat (19) @(negedge clk);
        checks++; if (timer_sec !== 4'd1) begin errors++; $display("FAIL tmo_c29: got %0d expected 1", timer_sec); end
        @(negedge clk);
        checks++; if (timer_sec !== 4'd3) begin errors++; $display("FAIL tmo_c30: got %0d expected 3", timer_sec); end
        do_move(4'd0);
        wait_frame();
        checks++; if (board !== 18'h00002) begin errors++; $display("FAIL tmo_forfeit: got %h expected 00002", board); end
        do_start();
        repeat (29) @(negedge clk);
        move_valid = 1'b1;
        move_cell  = 4'd0;
        @(negedge clk) move_valid = 1'b0;
        checks++; if (move_ready !== 1'b0 || timer_sec !== 4'd1) begin errors++;
            $display("FAIL tmo_race: got %b/%0d expected 0/1", move_ready, timer_sec); end
        @(negedge clk);
        checks++; if (timer_sec !== 4'd3) begin errors++; $display("FAIL tmo_reload: got %0d expected 3", timer_sec); end
        wait_frame();
        checks++; if (board !== 18'h00001) begin errors++; $display("FAIL tmo_xmove: got %h expected 00001", board); end
    endtask

    task automatic test_snapshot();
        align_fcnt(40);
        do_start();
        align_fcnt(49);
        @(negedge clk);
        move_valid = 1'b1;
        move_cell  = 4'd8;
        @(negedge clk) move_valid = 1'b0;
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL snap_same_edge: got %h expected 0", board); end
        repeat (10) @(negedge clk);
        checks++; if (board !== 18'h0) begin errors++; $display("FAIL snap_hold: got %h expected 0", board); end
        wait_frame();
        checks++; if (board !== 18'h10000) begin errors++; $display("FAIL snap_next: got %h expected 10000", board); end
        do_start();
        wait_frame();
        checks++; if (board !== 18'h0 || game_state !== 2'b01) begin errors++;
            $display("FAIL snap_restart: got %h/%b expected 0/01", board, game_state); end
        checks++; if ({winner, win_line} !== 10'h0) begin errors++;
            $display("FAIL snap_restart_res: got %h expected 0", {winner, win_line}); end
    endtask

    task automatic test_async_reset();
        do_start();
        do_move(4'd0);
        wait_frame();
        checks++; if (board !== 18'h00001 || game_state !== 2'b01) begin errors++;
            $display("FAIL ar_pre: got %h/%b expected 00001/01", board, game_state); end
        @(negedge clk);
        move_valid = 1'b1;
        move_cell  = 4'd4;
        @(negedge clk) move_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({board, turn, game_state, winner, win_line} !== 31'h0) begin errors++;
            $display("FAIL ar_snap: got %h expected 0", {board, turn, game_state, winner, win_line}); end
        checks++; if ({move_ready, move_reject, timer_sec} !== 6'h0) begin errors++;
            $display("FAIL ar_ctrl: got %h expected 0", {move_ready, move_reject, timer_sec}); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        move_valid = 1'b1;
        move_cell  = 4'd4;
        @(negedge clk) move_valid = 1'b0;
        checks++; if ({move_ready, move_reject} !== 2'b00) begin errors++;
            $display("FAIL ar_ignore: got %b expected 00", {move_ready, move_reject}); end
        wait_frame();
        checks++; if (board !== 18'h0 || game_state !== 2'b00) begin errors++;
            $display("FAIL ar_frame: got %h/%b expected 0/00", board, game_state); end
        do_start();
        checks++; if (move_ready !== 1'b1 || timer_sec !== 4'd3) begin errors++;
            $display("FAIL ar_restart: got %b/%0d expected 1/3", move_ready, timer_sec); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_draw();
        test_reject();
        test_timeout();
        test_snapshot();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
